// File: rtl/vram_portb_arbiter.sv
// Round-robin arbiter that shares VRAM port B among NREQ requesters, with
// blanking-only write gating, range checking and an in-order tagged read-return pipeline.
module vram_portb_arbiter #(
    parameter int NREQ          = 3,
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 9,
    parameter int VRAM_DEPTH    = 460800,
    parameter int RD_LAT        = 1,
    parameter int WR_BLANK_ONLY = 1
) (
    input  logic                     clk_25mhz,
    input  logic                     RST_N,
    input  logic                     vga_block,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdat,
    input  logic [DATA_W-1:0]        vram_doutb,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     addr_err,
    output logic [ADDR_W-1:0]        vram_addrb,
    output logic [DATA_W-1:0]        vram_dinb,
    output logic                     vram_web,
    output logic                     vram_enb
);

    localparam int              TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(VRAM_DEPTH);

    typedef struct packed {
        logic             valid;
        logic             oor;
        logic [TAG_W-1:0] tag;
    } rd_slot_t;

    logic [TAG_W-1:0]  ptr;
    logic [TAG_W-1:0]  ptr_next;
    logic [TAG_W-1:0]  winner;
    logic [TAG_W-1:0]  scan_idx;
    int                scan_int;
    logic              granted;
    logic [NREQ-1:0]   eligible;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdat;
    logic              win_we;
    logic              win_oor;
    rd_slot_t          pipe_in;
    rd_slot_t          pipe [RD_LAT];
    logic              rd_oor;

    // Gating with RST_N keeps gnt low while reset is held, even with requests pending.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = RST_N && req[i] && !(we[i] && (WR_BLANK_ONLY != 0) && vga_block);
        end
    end

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        granted  = 1'b0;
        winner   = '0;
        scan_int = 0;
        scan_idx = '0;
        gnt      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_int = int'(ptr) + k;
            if (scan_int >= NREQ) scan_int = scan_int - NREQ;
            scan_idx = TAG_W'(scan_int);
            if (!granted && eligible[scan_idx]) begin
                granted = 1'b1;
                winner  = scan_idx;
            end
        end
        if (granted) gnt[winner] = 1'b1;
    end

    assign ptr_next = (winner == TAG_W'(NREQ - 1)) ? '0 : winner + 1'b1;
    assign win_addr = addr[winner*ADDR_W +: ADDR_W];
    assign win_wdat = wdat[winner*DATA_W +: DATA_W];
    assign win_we   = we[winner];
    assign win_oor  = {1'b0, win_addr} >= DEPTH;

    // An out-of-range grant still consumes its turn but never touches the memory.
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            ptr        <= '0;
            vram_addrb <= '0;
            vram_dinb  <= '0;
            vram_web   <= 1'b0;
            vram_enb   <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            vram_enb <= granted && !win_oor;
            vram_web <= granted && win_we && !win_oor;
            addr_err <= granted && win_oor;
            if (granted) begin
                ptr        <= ptr_next;
                vram_addrb <= win_addr;
                vram_dinb  <= win_wdat;
            end
        end
    end

    assign pipe_in = '{valid: granted && !win_we, oor: win_oor, tag: winner};

    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the return pipeline is a handful of flops, so it is fully reset to drop in-flight reads.
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
            rvalid <= '0;
            rd_oor <= 1'b0;
        end else begin
            pipe[0] <= pipe_in;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            rvalid <= pipe[RD_LAT-1].valid ? (NREQ'(1) << pipe[RD_LAT-1].tag) : '0;
            rd_oor <= pipe[RD_LAT-1].oor;
        end
    end

    // Memory data arrives in the same cycle as the registered rvalid.
    assign rdata = (|rvalid && !rd_oor) ? vram_doutb : '0;

endmodule

// File: tb/tb_vram_portb_arbiter.sv
// Scoreboard bench for vram_portb_arbiter: a behavioural port-B memory answers reads,
// and expected returns are queued at grant time and compared when rvalid is due.
module tb_vram_portb_arbiter;

    localparam int DEPTH = 460800;

    typedef struct {
        int         cyc;
        logic [2:0] rv;
        logic [8:0] data;
    } sb_t;

    logic        clk_25mhz = 1'b0;
    logic        RST_N     = 1'b0;
    logic        vga_block = 1'b0;
    logic [2:0]  req       = '0;
    logic [2:0]  we        = '0;
    logic [56:0] addr      = '0;
    logic [26:0] wdat      = '0;
    logic [8:0]  vram_doutb;
    logic [2:0]  gnt, rvalid;
    logic [8:0]  rdata, vram_dinb;
    logic [18:0] vram_addrb;
    logic        addr_err, vram_web, vram_enb;

    logic [2:0]  nb_req = '0, nb_we = '0, nb_gnt, nb_rvalid;
    logic [56:0] nb_addr = '0;
    logic [26:0] nb_wdat = '0;
    logic [8:0]  nb_rdata, nb_dinb;
    logic [18:0] nb_addrb;
    logic        nb_err, nb_web, nb_enb;

    logic [8:0]  vram_mem [int];
    logic [8:0]  exp_mem  [int];
    sb_t         sb [$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    vram_portb_arbiter dut (
        .clk_25mhz(clk_25mhz), .RST_N(RST_N), .vga_block(vga_block),
        .req(req), .we(we), .addr(addr), .wdat(wdat), .vram_doutb(vram_doutb),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .addr_err(addr_err),
        .vram_addrb(vram_addrb), .vram_dinb(vram_dinb), .vram_web(vram_web), .vram_enb(vram_enb)
    );

    vram_portb_arbiter #(.WR_BLANK_ONLY(0)) dut_nb (
        .clk_25mhz(clk_25mhz), .RST_N(RST_N), .vga_block(vga_block),
        .req(nb_req), .we(nb_we), .addr(nb_addr), .wdat(nb_wdat), .vram_doutb(9'd0),
        .gnt(nb_gnt), .rvalid(nb_rvalid), .rdata(nb_rdata), .addr_err(nb_err),
        .vram_addrb(nb_addrb), .vram_dinb(nb_dinb), .vram_web(nb_web), .vram_enb(nb_enb)
    );

    function automatic logic [8:0] pattern(int a);
        return 9'((a * 37 + 11) ^ (a >> 9));
    endfunction

    // Port-B memory with one cycle of read latency.
    always @(posedge clk_25mhz) begin
        if (vram_enb) begin
            if (vram_web) vram_mem[int'(vram_addrb)] = vram_dinb;
            else vram_doutb <= vram_mem.exists(int'(vram_addrb)) ? vram_mem[int'(vram_addrb)]
                                                                 : pattern(int'(vram_addrb));
        end
    end

    task automatic set_port(int i, logic w, int a, logic [8:0] d);
        we[i]             = w;
        addr[i*19 +: 19]  = 19'(a);
        wdat[i*9 +: 9]    = d;
    endtask

    task automatic push_read(int i, int a);
        sb_t e;
        e.cyc  = cyc + 2;
        e.rv   = 3'(1 << i);
        e.data = (a >= DEPTH) ? 9'd0 : (exp_mem.exists(a) ? exp_mem[a] : pattern(a));
        sb.push_back(e);
    endtask

    task automatic cycle_begin();
        @(posedge clk_25mhz);
        #1;
        cyc++;
    endtask

    // Samples at the falling edge and retires any scoreboard entry that is due.
    task automatic sample();
        @(negedge clk_25mhz);
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL sb_missed: rvalid never came, required %b at cycle %0d", sb[0].rv, sb[0].cyc);
            void'(sb.pop_front());
        end
        checks++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            if (rvalid !== sb[0].rv || rdata !== sb[0].data) begin
                errors++;
                $display("FAIL sb_return: cycle %0d got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                         cyc, rvalid, rdata, sb[0].rv, sb[0].data);
            end
            void'(sb.pop_front());
        end else if (rvalid !== 3'b000) begin
            errors++;
            $display("FAIL sb_unexpected: cycle %0d got rvalid=%b, required 000", cyc, rvalid);
        end
        checks++;
        if (nb_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL nb_rvalid: got %b, required 000", nb_rvalid);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            req = '0;
            sample();
        end
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        sample();
        checks++;
        if ({gnt, addr_err, vram_web, vram_enb} !== 6'd0 || {rdata, vram_addrb, vram_dinb} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b err=%b web=%b enb=%b rdata=%h addrb=%0d dinb=%h, required all 0",
                     gnt, addr_err, vram_web, vram_enb, rdata, vram_addrb, vram_dinb);
        end
    endtask

    task automatic test_single_read();
        cycle_begin();
        req = 3'b010; set_port(1, 1'b0, 960, 9'd0);
        sample();
        checks++;
        if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt: got %b, required 010", gnt); end
        push_read(1, 960);
        cycle_begin();
        req = '0;
        sample();
        checks++;
        if (vram_enb !== 1'b1 || vram_web !== 1'b0 || vram_addrb !== 19'd960) begin
            errors++;
            $display("FAIL single_issue: enb=%b web=%b addrb=%0d, required 1 0 960", vram_enb, vram_web, vram_addrb);
        end
        idle(3);
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 3; i++) set_port(i, 1'b0, 2000 + i * 17, 9'd0);
        for (int n = 0; n < 9; n++) begin
            cycle_begin();
            req = 3'b111;
            for (int i = 0; i < 3; i++) addr[i*19 +: 19] = 19'(2000 + n * 50 + i);
            sample();
            checks++;
            if (gnt !== 3'(1 << (n % 3))) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: got %b, required %b", n, gnt, 3'(1 << (n % 3)));
            end
            push_read(n % 3, 2000 + n * 50 + (n % 3));
        end
        idle(4);
    endtask

    task automatic test_blank_gating();
        cycle_begin();
        vga_block = 1'b1; req = 3'b101;
        set_port(0, 1'b1, 5, 9'h0FF);
        set_port(2, 1'b0, 100, 9'd0);
        sample();
        checks++;
        if (gnt !== 3'b100) begin errors++; $display("FAIL blank_gnt_read: got %b, required 100", gnt); end
        push_read(2, 100);
        cycle_begin();
        req = 3'b001;
        sample();
        checks++;
        if (gnt !== 3'b000 || vram_web !== 1'b0 || vram_enb !== 1'b1) begin
            errors++;
            $display("FAIL blank_hold: gnt=%b web=%b enb=%b, required 000 0 1", gnt, vram_web, vram_enb);
        end
        cycle_begin();
        vga_block = 1'b0;
        sample();
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL blank_gnt_write: got %b, required 001", gnt); end
        exp_mem[5] = 9'h0FF;
        cycle_begin();
        req = '0;
        sample();
        checks++;
        if (vram_web !== 1'b1 || vram_enb !== 1'b1 || vram_dinb !== 9'h0FF || vram_addrb !== 19'd5) begin
            errors++;
            $display("FAIL blank_write_issue: web=%b enb=%b dinb=%h addrb=%0d, required 1 1 0ff 5",
                     vram_web, vram_enb, vram_dinb, vram_addrb);
        end
        cycle_begin();
        req = 3'b010; set_port(1, 1'b0, 5, 9'd0);
        sample();
        checks++;
        if (gnt !== 3'b010) begin errors++; $display("FAIL blank_readback_gnt: got %b, required 010", gnt); end
        push_read(1, 5);
        idle(4);
    endtask

    task automatic test_out_of_range();
        cycle_begin();
        req = 3'b100; set_port(2, 1'b0, DEPTH, 9'd0);
        sample();
        checks++;
        if (gnt !== 3'b100) begin errors++; $display("FAIL oor_gnt: got %b, required 100", gnt); end
        push_read(2, DEPTH);
        cycle_begin();
        req = '0;
        sample();
        checks++;
        if (addr_err !== 1'b1 || vram_enb !== 1'b0 || vram_web !== 1'b0) begin
            errors++;
            $display("FAIL oor_issue: err=%b enb=%b web=%b, required 1 0 0", addr_err, vram_enb, vram_web);
        end
        cycle_begin();
        req = 3'b111;
        for (int i = 0; i < 3; i++) set_port(i, 1'b0, DEPTH - 1, 9'd0);
        sample();
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL oor_ptr_wrap: got %b, required 001", gnt); end
        push_read(0, DEPTH - 1);
        cycle_begin();
        req = 3'b001; set_port(0, 1'b1, DEPTH, 9'h155);
        sample();
        checks++;
        if (addr_err !== 1'b0 || vram_enb !== 1'b1 || vram_addrb !== 19'(DEPTH - 1)) begin
            errors++;
            $display("FAIL edge_issue: err=%b enb=%b addrb=%0d, required 0 1 %0d", addr_err, vram_enb, vram_addrb, DEPTH - 1);
        end
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL oor_wr_gnt: got %b, required 001", gnt); end
        cycle_begin();
        req = '0;
        sample();
        checks++;
        if (addr_err !== 1'b1 || vram_web !== 1'b0 || vram_enb !== 1'b0) begin
            errors++;
            $display("FAIL oor_wr_issue: err=%b web=%b enb=%b, required 1 0 0", addr_err, vram_web, vram_enb);
        end
        idle(4);
    endtask

    task automatic test_reset_mid_read();
        cycle_begin();
        req = 3'b010; set_port(1, 1'b0, 300, 9'd0);
        sample();
        checks++;
        if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_gnt: got %b, required 010", gnt); end
        cycle_begin();
        req = 3'b111;
        for (int i = 0; i < 3; i++) set_port(i, 1'b0, 400 + i, 9'd0);
        RST_N = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({gnt, rvalid, addr_err, vram_web, vram_enb} !== 9'd0 || vram_addrb !== 19'd0) begin
            errors++;
            $display("FAIL midrst_async: gnt=%b rvalid=%b err=%b web=%b enb=%b addrb=%0d, required all 0",
                     gnt, rvalid, addr_err, vram_web, vram_enb, vram_addrb);
        end
        repeat (2) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        req   = '0;
        RST_N = 1'b1;
        idle(4);
        cycle_begin();
        req = 3'b111;
        sample();
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_first_gnt: got %b, required 001", gnt); end
        push_read(0, 400);
        idle(4);
    endtask

    task automatic test_write_no_blank();
        cycle_begin();
        vga_block = 1'b1;
        nb_req = 3'b001; nb_we = 3'b001;
        nb_addr[0 +: 19] = 19'd77; nb_wdat[0 +: 9] = 9'h0AA;
        sample();
        checks++;
        if (nb_gnt !== 3'b001) begin errors++; $display("FAIL nb_gnt: got %b, required 001", nb_gnt); end
        cycle_begin();
        nb_req = '0;
        sample();
        checks++;
        if (nb_web !== 1'b1 || nb_enb !== 1'b1 || nb_dinb !== 9'h0AA || nb_addrb !== 19'd77) begin
            errors++;
            $display("FAIL nb_issue: web=%b enb=%b dinb=%h addrb=%0d, required 1 1 0aa 77", nb_web, nb_enb, nb_dinb, nb_addrb);
        end
        idle(4);
        vga_block = 1'b0;
    endtask

    initial begin
        vram_mem[960] = 9'h1A5;
        exp_mem[960]  = 9'h1A5;
        test_reset();
        test_single_read();
        test_round_robin();
        test_blank_gating();
        test_out_of_range();
        test_reset_mid_read();
        test_write_no_blank();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending returns, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_portb_arbiter.md
# vram_portb_arbiter

Shares port B of the 960x480 background VRAM among several requesters (tile-update writer, collision probe, debug reader) with round-robin arbitration. It sits beside the display path. Port A stays owned by the scan-out address generator, and port B is driven only by this block. Writes can be held off during the active display area so that background edits land only in blanking. Read data returns in request order through a fixed-latency pipeline tagged with the requester index.

## Interface
- NREQ, 3: number of requesters (2..8).
- ADDR_W, 19: VRAM address width.
- DATA_W, 9: VRAM word width (3R3G3B).
- VRAM_DEPTH, 460800: valid address range, 0..VRAM_DEPTH-1.
- RD_LAT, 1: VRAM port-B read latency in cycles (1..3).
- WR_BLANK_ONLY, 1: when 1, writes are ineligible while vga_block=1.

Ports:
- clk_25mhz  in  1  pixel clock.
- RST_N  in  1  reset, asynchronous, active-low.
- vga_block  in  1  high during the active display area.
- req  in  NREQ  per-requester request level.
- we  in  NREQ  per-requester write flag (0 = read).
- addr  in  NREQ*ADDR_W  flattened addresses; requester i uses [i*ADDR_W +: ADDR_W].
- wdat  in  NREQ*DATA_W  flattened write data.
- gnt  out  NREQ  one-hot acceptance strobe (combinational).
- rvalid  out  NREQ  one-hot read-return strobe (registered).
- rdata  out  DATA_W  read data, valid when any rvalid bit is high.
- addr_err  out  1  one-cycle pulse for an out-of-range access.
- vram_addrb  out  ADDR_W  port-B address.
- vram_dinb  out  DATA_W  port-B write data.
- vram_web  out  1  port-B write enable.
- vram_enb  out  1  port-B enable.

## Operation
- Eligibility: a requester i is eligible when req[i]=1 and not (we[i]=1 and WR_BLANK_ONLY=1 and vga_block=1).
- Arbitration: round-robin pointer ptr, range 0..NREQ-1, reset value 0.
  - The winner is the first eligible index scanning ptr, ptr+1, … with mod-NREQ wrap.
  - gnt[winner]=1 in the same cycle. At most one gnt bit is set per cycle.
  - On a grant, ptr <= winner+1 (mod NREQ). With no grant, ptr holds.
- Requester contract:
  - Hold req, we, addr and wdat stable until it sees gnt.
  - A requester may drop req before being granted; it then cannot be granted.
  - To issue a back-to-back request, keep req high after gnt.
- Issue stage (registered):
  - On a grant, drive vram_addrb=addr, vram_dinb=wdat, vram_web=we and vram_enb=1 for exactly one cycle.
  - With no grant, drive vram_enb=0 and vram_web=0. vram_addrb and vram_dinb hold their previous values.
- Range check:
  - If the granted addr >= VRAM_DEPTH, the access is still granted and still advances ptr.
  - The issue cycle then drives vram_enb=0 and vram_web=0, and addr_err pulses in the issue cycle.
  - An out-of-range read still returns: rvalid fires at normal latency with rdata=0.
- Read return pipeline:
  - Depth RD_LAT. It carries a valid bit, the requester index and an out-of-range bit.
  - Writes produce no rvalid.
  - The pipeline accepts one read per cycle, so full throughput needs no stalls.
- vga_block changes only eligibility. A write already granted completes even if vga_block rises in its issue cycle.

## Timing
- Cycle N: req/addr are sampled and gnt is asserted combinationally.
- Cycle N+1: port-B signals are driven (issue cycle).
- Cycle N+1+RD_LAT: rvalid[i] is registered high and rdata is valid. With RD_LAT=1, that is 2 cycles after gnt.
- Throughput is 1 access per cycle. Each requester gets at least one grant per NREQ cycles while it stays continuously eligible.
- Reset values:
  - gnt, rvalid, addr_err, vram_web and vram_enb are 0.
  - rdata, vram_addrb and vram_dinb are 0.
  - ptr is 0.
- Reset asserted mid-operation:
  - All in-flight reads are discarded; no rvalid appears after reset is released.
  - A port-B write being issued in the asserting cycle is aborted: vram_enb and vram_web drop asynchronously.
- Simultaneous events: with all requests eligible and ptr=k, requester k wins. Write gating never blocks a read from a lower-priority requester.

## Test plan
- Single read: ptr=0, requester 1 reads addr 960 (memory holds 0x1A5). Expect gnt=3'b010 in cycle 0, vram_enb=1 with addrb=960 in cycle 1, and rvalid=3'b010 with rdata=0x1A5 in cycle 2.
- Round robin: all three requesters hold reads continuously for 9 cycles. Expect the gnt sequence 001,010,100 repeated three times, and rvalid in the same order two cycles later.
- Blank gating: requester 0 writes 0x0FF to addr 5 and requester 2 reads, both with vga_block=1. Expect only requester 2 granted. When vga_block falls, requester 0 is granted on that cycle, and vram_web=1 with dinb=0x0FF one cycle later.
- Out of range: requester 2 reads addr 460800. Expect gnt, then addr_err=1 with vram_enb=0, then rvalid=3'b100 with rdata=0. ptr advances to 0.
- Reset mid-read: assert RST_N=0 one cycle after a granted read. Expect all outputs 0 immediately, no rvalid after release, and the first post-reset grant going to requester 0.
- Write with WR_BLANK_ONLY=0: a write during vga_block=1 is granted immediately, and rvalid stays 0 throughout.
